dmem_responder: RTL and testbench
=================================

# dmem_responder

Handshaked data-memory responder that serves load/store requests from the CPU's data port, replacing the zero-latency behavioral data memory. It accepts one request at a time, inserts a fixed number of wait states, and performs the access. It then holds the response until the requester takes it. It sits between the CPU load/store path and the word storage array.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored
- BASE_ADDR, 32'h10010000, byte address of word 0 (data segment)
- WAIT_CYCLES, 2, wait states between acceptance and response (0..15)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  store byte enables; bit i covers bits 8i+7:8i
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes the response
- rsp_rdata  out  32  load data; 0 for stores
- rsp_err  out  1  access rejected: misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid&&req_ready, latch we/addr/wdata/be.
  - WAIT_CYCLES>0: load the counter with WAIT_CYCLES and go to WAIT.
  - WAIT_CYCLES=0: go directly to RESP.
- WAIT: decrement the counter each cycle. At count 1, perform the access and go to RESP.
- Access commit happens on the edge entering RESP.
  - Store: write only the enabled bytes. rsp_rdata=0.
  - Load: rsp_rdata = full word. req_be is ignored.
- RESP: hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready. On the edge with rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid.
- Error check (req_addr[1:0]!=0, or addr<BASE_ADDR, or addr>=BASE_ADDR+4*DEPTH_WORDS):
  - No write.
  - rsp_err=1.
  - rsp_rdata=32'hDEADBEEF for loads, 0 for stores.
  - The full wait latency is still applied.
- Word index = (req_addr-BASE_ADDR)>>2, computed in 32-bit unsigned arithmetic. Wrap-around below BASE_ADDR counts as out of range.
- req_be=4'b0000 store: legal no-op, rsp_err=0.
- Storage contents are not cleared by reset. Reading a never-written word returns an undefined value. The bench must write before reading.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-operation returns immediately to IDLE.
  - A store not yet committed is dropped.
  - A committed store persists.
- Latency: request accepted on edge T. rsp_valid=1 in the cycle after edge T+WAIT_CYCLES. With WAIT_CYCLES=0, that is the cycle after edge T.
- req_ready is a decode of state==IDLE. It is low throughout WAIT and RESP, and the requester must hold req_valid.
- Back-to-back throughput: after the response handshake on edge R, req_ready=1 in the next cycle. The next accept is at earliest edge R+1. Max one access per WAIT_CYCLES+2 cycles.
- rsp_ready held high early has no effect before RESP. rsp_ready=0 stalls indefinitely with outputs stable.

## Structure
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - DMEM_ERR_DATA = 32'hDEADBEEF
  - DMEM_BASE_ADDR = 32'h10010000
- Sub-module dmem_word_array:
  - DEPTH_WORDS x 32 synchronous array
  - ports: clk, we, be[3:0], idx, wdata, rdata
  - byte-masked write; registered read on the commit edge
- The FSM, wait counter and range/alignment check live in dmem_responder.

## Test plan
- Store 32'hCAFEF00D to 0x10010000, be=4'hF, then load the same address. Expect rsp_rdata=32'hCAFEF00D, rsp_err=0, rsp_valid rising WAIT_CYCLES+1 cycles after each accept.
- Byte-enable merge: store 32'h11223344 (be=F), then 32'hAABBCCDD with be=4'b0101, then load. Expect 32'h11BB33DD.
- Errors:
  - Load 0x10010002 → rsp_err=1, rsp_rdata=32'hDEADBEEF.
  - Store to 0x0FFFFFFC → rsp_err=1, memory unchanged.
  - Load at BASE_ADDR+4*DEPTH_WORDS → rsp_err=1.
- Backpressure: hold rsp_ready=0 for 10 cycles. Expect rsp_valid/rsp_rdata stable and req_ready=0 throughout. Release and expect return to IDLE.
- Reset in WAIT during a store to 0x10010004 (previously 32'h5). Expect outputs at reset values, and a subsequent load returns 32'h5.
- WAIT_CYCLES=0 build: accept on edge T, rsp_valid in cycle T+1. Back-to-back loads with rsp_ready tied high complete every 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    localparam logic [31:0] DMEM_ERR_DATA  = 32'hDEADBEEF;
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h10010000;

    // An access is rejected when it is misaligned, below the window, or at/after its end.
    // The offset wraps for addresses below base, which the explicit compare also catches.
    function automatic logic dmem_addr_err(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] span);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || (off >= span);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the CPU data port and the responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_word_array.sv
// Word storage: byte-masked synchronous write, registered read. Contents survive reset.
module dmem_word_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write only the enabled bytes; read the addressed word every edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, fixed wait states,
// response held until taken. Errors (misaligned / out of window) never write.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

    dmem_state_e state;
    logic [3:0]  cnt;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        rsp_err_q;
    logic        rsp_load_q;
    logic [31:0] rsp_fixed_q;

    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [31:0]      acc_off;
    logic [3:0]       acc_be;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic             commit;
    logic             arr_we;
    logic [31:0]      arr_rdata;

    // In IDLE the access is described by the live request (needed for zero wait
    // states, where the commit is the accept edge); otherwise by the latched copy,
    // which keeps the array index stable so the read word holds through RESP.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end
        acc_off = acc_addr - BASE_ADDR;
        acc_idx = IDX_W'(acc_off >> 2);
        acc_err = dmem_addr_err(acc_addr, BASE_ADDR, SPAN);
    end

    // The access commits on the edge that enters RESP; never while reset is asserted.
    always_comb begin
        commit = 1'b0;
        if (rst) begin
            if (state == WAIT && cnt == 4'd1) begin
                commit = 1'b1;
            end
            if (WAIT_CYCLES == 0 && state == IDLE && bus.req_valid) begin
                commit = 1'b1;
            end
        end
        arr_we = commit && acc_we && !acc_err;
    end

    dmem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .be   (acc_be),
        .idx  (acc_idx),
        .wdata(acc_wdata),
        .rdata(arr_rdata)
    );

    // Control FSM, wait counter and registered response status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_fixed_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                rsp_err_q   <= acc_err;
                rsp_load_q  <= !acc_we && !acc_err;
                rsp_fixed_q <= (acc_err && !acc_we) ? DMEM_ERR_DATA : 32'h0;
            end
        end
    end

    // Capture the request on acceptance; data path only, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_load_q ? arr_rdata : rsp_fixed_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one zero-wait and one two-wait instance, a behavioural
// memory/timing model, a per-cycle compare process and directed literal checks.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        rv[2];
    logic        rwe[2];
    logic        rr[2];
    logic [31:0] raddr[2];
    logic [31:0] rwd[2];
    logic [3:0]  rbe[2];
    logic        rdy[2];
    logic        vld[2];
    logic        err_o[2];
    logic [31:0] rd_o[2];

    dmem_responder_if if0();
    dmem_responder_if if1();

    assign if0.req_valid = rv[0];
    assign if0.req_we    = rwe[0];
    assign if0.req_addr  = raddr[0];
    assign if0.req_wdata = rwd[0];
    assign if0.req_be    = rbe[0];
    assign if0.rsp_ready = rr[0];
    assign rdy[0]   = if0.req_ready;
    assign vld[0]   = if0.rsp_valid;
    assign err_o[0] = if0.rsp_err;
    assign rd_o[0]  = if0.rsp_rdata;

    assign if1.req_valid = rv[1];
    assign if1.req_we    = rwe[1];
    assign if1.req_addr  = raddr[1];
    assign if1.req_wdata = rwd[1];
    assign if1.req_be    = rbe[1];
    assign if1.rsp_ready = rr[1];
    assign rdy[1]   = if1.req_ready;
    assign vld[1]   = if1.rsp_valid;
    assign err_o[1] = if1.rsp_err;
    assign rd_o[1]  = if1.rsp_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic int wait_of(input int w);
        return (w == 0) ? 0 : 2;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mm[2][DEPTH];
    bit          mk[2][DEPTH];
    int          m_st[2] = '{0, 0};   // 0 free, 1 pending, 2 response shown
    int          m_due[2];
    bit          p_we[2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wd[2];
    logic [3:0]  p_be[2];
    logic [31:0] e_rd[2];
    bit          e_err[2];
    bit          e_known[2];
    int          cyc = 0;

    function automatic bit addr_bad(input logic [31:0] a);
        longint la;
        la = {32'd0, a};
        return (la % 4 != 0) || (la < longint'({32'd0, BASE})) ||
               (la >= longint'({32'd0, BASE}) + 4 * DEPTH);
    endfunction

    task automatic model_commit(input int w);
        int idx;
        e_known[w] = 1'b1;
        e_err[w]   = addr_bad(p_addr[w]);
        e_rd[w]    = 32'h0;
        if (e_err[w]) begin
            if (!p_we[w]) e_rd[w] = 32'hDEADBEEF;
        end else begin
            idx = int'((p_addr[w] - BASE) / 4);
            if (p_we[w]) begin
                for (int b = 0; b < 4; b++) begin
                    if (p_be[w][b]) mm[w][idx][8*b +: 8] = p_wd[w][8*b +: 8];
                end
                if (p_be[w] == 4'hF) mk[w][idx] = 1'b1;
            end else begin
                e_rd[w]    = mm[w][idx];
                e_known[w] = mk[w][idx];
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int w = 0; w < 2; w++) begin
            if (!rst) begin
                m_st[w] = 0;
            end else begin
                if (m_st[w] == 0) begin
                    if (rv[w]) begin
                        p_we[w]   = rwe[w];
                        p_addr[w] = raddr[w];
                        p_wd[w]   = rwd[w];
                        p_be[w]   = rbe[w];
                        m_due[w]  = cyc + wait_of(w);
                        m_st[w]   = 1;
                    end
                end else if (m_st[w] == 2) begin
                    if (rr[w]) m_st[w] = 0;
                end
                if (m_st[w] == 1 && cyc == m_due[w]) begin
                    model_commit(w);
                    m_st[w] = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (!rst) begin
                m_st[w] = 0;
                check32($sformatf("w%0d reset req_ready", w), {31'd0, rdy[w]}, 32'd1);
                check32($sformatf("w%0d reset rsp_valid", w), {31'd0, vld[w]}, 32'd0);
                check32($sformatf("w%0d reset rsp_err", w), {31'd0, err_o[w]}, 32'd0);
                check32($sformatf("w%0d reset rsp_rdata", w), rd_o[w], 32'd0);
            end else begin
                check32($sformatf("w%0d req_ready", w), {31'd0, rdy[w]}, {31'd0, m_st[w] == 0});
                check32($sformatf("w%0d rsp_valid", w), {31'd0, vld[w]}, {31'd0, m_st[w] == 2});
                if (m_st[w] == 2) begin
                    check32($sformatf("w%0d rsp_err", w), {31'd0, err_o[w]}, {31'd0, e_err[w]});
                    if (e_known[w]) check32($sformatf("w%0d rsp_rdata", w), rd_o[w], e_rd[w]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int w, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int hold, input bit early,
                          output logic [31:0] rd, output bit er, output int lat);
        int n;
        bit seen;
        rd  = 32'h0;
        er  = 1'b0;
        lat = 0;
        @(posedge clk);
        #1;
        rv[w] = 1'b1; rwe[w] = we; raddr[w] = addr; rwd[w] = wd; rbe[w] = be; rr[w] = 1'b0;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = rdy[w];
            @(posedge clk);
            n++;
        end
        #1;
        rv[w] = 1'b0;
        if (!seen) begin
            fail_now($sformatf("w%0d accept", w));
            return;
        end
        if (early) rr[w] = 1'b1;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = vld[w];
        end
        lat = n;
        if (!seen) begin
            rr[w] = 1'b0;
            fail_now($sformatf("w%0d response", w));
            return;
        end
        rd = rd_o[w];
        er = err_o[w];
        if (!early) begin
            repeat (hold) @(negedge clk);
            @(posedge clk);
            #1 rr[w] = 1'b1;
        end
        @(posedge clk);
        #1 rr[w] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [3:0]  be;
        bit          er;
        bit          we;
        int          lat;
        int          kind;
        int          wi;
        int          na;
        int          nv;

        for (int w = 0; w < 2; w++) begin
            rv[w] = 1'b0; rwe[w] = 1'b0; rr[w] = 1'b0;
            raddr[w] = 32'h0; rwd[w] = 32'h0; rbe[w] = 4'h0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // two-wait instance: basic store/load with latency
        do_req(1, 1, BASE, 32'hCAFEF00D, 4'hF, 0, 0, rd, er, lat);
        check32("w1 store err", {31'd0, er}, 32'd0);
        check32("w1 store rdata", rd, 32'h0);
        check32("w1 store latency", 32'(lat), 32'd3);
        do_req(1, 0, BASE, 32'h0, 4'h0, 0, 0, rd, er, lat);
        check32("w1 load rdata", rd, 32'hCAFEF00D);
        check32("w1 load err", {31'd0, er}, 32'd0);
        check32("w1 load latency", 32'(lat), 32'd3);

        // byte-enable merge
        do_req(1, 1, BASE + 8, 32'h11223344, 4'hF, 0, 0, rd, er, lat);
        do_req(1, 1, BASE + 8, 32'hAABBCCDD, 4'b0101, 1, 0, rd, er, lat);
        do_req(1, 0, BASE + 8, 32'h0, 4'h0, 0, 0, rd, er, lat);
        check32("w1 merge rdata", rd, 32'h11BB33DD);

        // error cases
        do_req(1, 0, BASE + 2, 32'h0, 4'hF, 0, 0, rd, er, lat);
        check32("w1 misaligned err", {31'd0, er}, 32'd1);
        check32("w1 misaligned rdata", rd, 32'hDEADBEEF);
        check32("w1 misaligned latency", 32'(lat), 32'd3);
        do_req(1, 1, BASE + 4092, 32'h12345678, 4'hF, 0, 0, rd, er, lat);
        do_req(1, 1, 32'h0FFFFFFC, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lat);
        check32("w1 below-base err", {31'd0, er}, 32'd1);
        check32("w1 below-base rdata", rd, 32'h0);
        do_req(1, 0, BASE + 4092, 32'h0, 4'h0, 0, 0, rd, er, lat);
        check32("w1 last word intact", rd, 32'h12345678);
        check32("w1 last word err", {31'd0, er}, 32'd0);
        do_req(1, 0, BASE + 4096, 32'h0, 4'h0, 0, 0, rd, er, lat);
        check32("w1 past-end err", {31'd0, er}, 32'd1);
        check32("w1 past-end rdata", rd, 32'hDEADBEEF);

        // empty byte mask is a legal no-op
        do_req(1, 1, BASE + 8, 32'hFFFFFFFF, 4'h0, 0, 0, rd, er, lat);
        check32("w1 be0 err", {31'd0, er}, 32'd0);
        do_req(1, 0, BASE + 8, 32'h0, 4'h0, 0, 0, rd, er, lat);
        check32("w1 be0 unchanged", rd, 32'h11BB33DD);

        // backpressure and early rsp_ready
        do_req(1, 0, BASE, 32'h0, 4'h0, 10, 0, rd, er, lat);
        check32("w1 backpressure rdata", rd, 32'hCAFEF00D);
        do_req(1, 0, BASE, 32'h0, 4'h0, 0, 1, rd, er, lat);
        check32("w1 early ready rdata", rd, 32'hCAFEF00D);
        check32("w1 early ready latency", 32'(lat), 32'd3);

        // reset during WAIT drops the pending store
        do_req(1, 1, BASE + 4, 32'h5, 4'hF, 0, 0, rd, er, lat);
        @(posedge clk);
        #1;
        rv[1] = 1'b1; rwe[1] = 1'b1; raddr[1] = BASE + 4; rwd[1] = 32'h99; rbe[1] = 4'hF;
        @(posedge clk);
        #1;
        rv[1] = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check32("w1 in-reset req_ready", {31'd0, rdy[1]}, 32'd1);
        check32("w1 in-reset rsp_valid", {31'd0, vld[1]}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        do_req(1, 0, BASE + 4, 32'h0, 4'h0, 0, 0, rd, er, lat);
        check32("w1 store dropped by reset", rd, 32'h5);

        // zero-wait instance
        do_req(0, 1, BASE, 32'hCAFEF00D, 4'hF, 0, 0, rd, er, lat);
        check32("w0 store latency", 32'(lat), 32'd1);
        do_req(0, 0, BASE, 32'h0, 4'h0, 0, 0, rd, er, lat);
        check32("w0 load rdata", rd, 32'hCAFEF00D);
        check32("w0 load latency", 32'(lat), 32'd1);

        // back-to-back loads with rsp_ready tied high
        @(posedge clk);
        #1;
        rr[0] = 1'b1; rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = BASE; rbe[0] = 4'hF;
        na = 0;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (rdy[0]) na++;
            if (vld[0]) nv++;
        end
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        rr[0] = 1'b0;
        check32("w0 throughput accepts", 32'(na), 32'd10);
        check32("w0 throughput responses", 32'(nv), 32'd10);

        // randomized traffic checked by the model
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 80; i++) begin
                kind = $urandom_range(0, 9);
                wi   = $urandom_range(0, 15);
                we   = 1'($urandom_range(0, 1));
                a    = BASE + 32'(4 * wi);
                be   = 4'($urandom_range(0, 15));
                if (!we && !mk[w][wi]) we = 1'b1;
                if (we && !mk[w][wi]) be = 4'hF;
                if (kind == 0) begin
                    case ($urandom_range(0, 6))
                        0: a = BASE + 1;
                        1: a = BASE + 32'(4 * wi) + 3;
                        2: a = BASE - 4;
                        3: a = BASE + 4096;
                        4: a = 32'h0;
                        5: a = 32'hFFFFFFFC;
                        default: a = BASE + 32'(4 * wi) + 2;
                    endcase
                end
                do_req(w, we, a, $urandom, be, $urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0), rd, er, lat);
                check32($sformatf("w%0d random latency", w), 32'(lat), 32'(wait_of(w) + 1));
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
